// File: rtl/vdp_video_timing.sv
// Video timing regenerator: prescaled H/V counters, registered sync/blank decode and blank-gated RGB.
// Optional raw VDP sync/RGB bypass is compiled in with `VDP_TIMING_RAW_EN.
module vdp_video_timing #(
  parameter int COLOR_W      = 6,
  parameter int CNT_W        = 10,
  parameter int DIV          = 2,
  parameter int H_TOTAL      = 342,
  parameter int V_TOTAL_NTSC = 261,
  parameter int V_TOTAL_PAL  = 312,
  parameter int H_START      = 306,
  parameter int HS_WIDTH     = 20,
  parameter int VS_WIDTH     = 4,
  parameter int HBLANK_END   = 60,
  parameter int HBLANK_START = 341,
  parameter int VBLANK_LINES = 8
) (
  input  logic               clk,
  input  logic               RESET,
  input  logic               ena,
  input  logic               is_pal,
  input  logic               raw_sel,
  input  logic               vdp_hs_n,
  input  logic               vdp_vs_n,
  input  logic [COLOR_W-1:0] vdp_r,
  input  logic [COLOR_W-1:0] vdp_g,
  input  logic [COLOR_W-1:0] vdp_b,
  output logic               HS,
  output logic               VS,
  output logic [COLOR_W-1:0] R,
  output logic [COLOR_W-1:0] G,
  output logic [COLOR_W-1:0] B,
  output logic               HBlank,
  output logic               VBlank,
  output logic [CNT_W-1:0]   hcnt,
  output logic [CNT_W-1:0]   vcnt,
  output logic               pal,
  output logic               frame
);

  localparam int PDIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PDIV_W-1:0] PDIV_LAST = PDIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_INIT    = CNT_W'(H_START);
  localparam logic [CNT_W-1:0]  VN_LAST   = CNT_W'(V_TOTAL_NTSC - 1);
  localparam logic [CNT_W-1:0]  VP_LAST   = CNT_W'(V_TOTAL_PAL - 1);
  localparam logic [CNT_W-1:0]  HBE       = CNT_W'(HBLANK_END);
  localparam logic [CNT_W-1:0]  HBS       = CNT_W'(HBLANK_START);
  localparam logic [CNT_W-1:0]  HSW       = CNT_W'(HS_WIDTH);
  localparam logic [CNT_W-1:0]  VSW       = CNT_W'(VS_WIDTH);
  localparam logic [CNT_W-1:0]  VBL       = CNT_W'(VBLANK_LINES);

  logic [PDIV_W-1:0]  pdiv_q, pdiv_d;
  logic [CNT_W-1:0]   hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic               pal_q, pal_d, frame_q, frame_d;
  logic [1:0]         sync_q;
  logic               hs_q, hs_d, vs_q, vs_d, hb_q, hb_d, vb_q, vb_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               tick_s, line_end_s, frame_end_s, hb_s, vb_s, raw_s;

`ifdef VDP_TIMING_RAW_EN
  assign raw_s = raw_sel;
`else
  assign raw_s = 1'b0 & raw_sel;
`endif

  // Prescaler and H/V counters; the standard latches only when the frame wraps.
  always_comb begin
    pdiv_d      = pdiv_q;
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    pal_d       = pal_q;
    frame_d     = 1'b0;
    tick_s      = ena && (pdiv_q == PDIV_LAST);
    line_end_s  = (hcnt_q == H_LAST);
    frame_end_s = line_end_s && (vcnt_q == (pal_q ? VP_LAST : VN_LAST));
    if (ena) begin
      if (tick_s) pdiv_d = {PDIV_W{1'b0}};
      else        pdiv_d = pdiv_q + 1'b1;
    end else begin
      pdiv_d = pdiv_q;
    end
    if (tick_s) begin
      if (line_end_s) begin
        hcnt_d = {CNT_W{1'b0}};
        if (frame_end_s) begin
          vcnt_d  = {CNT_W{1'b0}};
          pal_d   = sync_q[1];
          frame_d = 1'b1;
        end else begin
          vcnt_d = vcnt_q + 1'b1;
        end
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
    end else begin
      hcnt_d = hcnt_q;
    end
  end

  // Sync/blank decode with colour capture, so gating lines up with the counter that produced it.
  always_comb begin
    hb_s = (hcnt_q < HBE) || (hcnt_q >= HBS);
    vb_s = (vcnt_q < VBL);
    hb_d = hb_s;
    vb_d = vb_s;
    hs_d = !(hcnt_q < HSW);
    vs_d = !(vcnt_q < VSW);
    r_d  = vdp_r;
    g_d  = vdp_g;
    b_d  = vdp_b;
    if (raw_s) begin
      hs_d = vdp_hs_n;
      vs_d = vdp_vs_n;
    end else if (hb_s || vb_s) begin
      r_d = {COLOR_W{1'b0}};
      g_d = {COLOR_W{1'b0}};
      b_d = {COLOR_W{1'b0}};
    end else begin
      r_d = vdp_r;
      g_d = vdp_g;
      b_d = vdp_b;
    end
  end

  // Counter, synchroniser and standard state.
  always_ff @(posedge clk) begin
    if (RESET) begin
      pdiv_q  <= {PDIV_W{1'b0}};
      hcnt_q  <= H_INIT;
      vcnt_q  <= {CNT_W{1'b0}};
      pal_q   <= 1'b0;
      sync_q  <= 2'b00;
      frame_q <= 1'b0;
    end else begin
      pdiv_q  <= pdiv_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      pal_q   <= pal_d;
      sync_q  <= {sync_q[0], is_pal};
      frame_q <= frame_d;
    end
  end

  // Registered video outputs.
  always_ff @(posedge clk) begin
    if (RESET) begin
      hs_q <= 1'b1;
      vs_q <= 1'b1;
      hb_q <= 1'b1;
      vb_q <= 1'b1;
      r_q  <= {COLOR_W{1'b0}};
      g_q  <= {COLOR_W{1'b0}};
      b_q  <= {COLOR_W{1'b0}};
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      hb_q <= hb_d;
      vb_q <= vb_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign HS     = hs_q;
  assign VS     = vs_q;
  assign HBlank = hb_q;
  assign VBlank = vb_q;
  assign R      = r_q;
  assign G      = g_q;
  assign B      = b_q;
  assign hcnt   = hcnt_q;
  assign vcnt   = vcnt_q;
  assign pal    = pal_q;
  assign frame  = frame_q;

endmodule

// File: tb/tb_vdp_video_timing.sv
// Bench for vdp_video_timing: default-geometry and reduced-geometry instances checked each cycle
// against a linear pixel-position model, plus literal expectations from the timing rules.
module tb_vdp_video_timing;

  localparam int HT  [0:1] = '{342, 40};
  localparam int VN  [0:1] = '{261, 21};
  localparam int VP  [0:1] = '{312, 26};
  localparam int HST [0:1] = '{306, 34};
  localparam int HSW [0:1] = '{20, 4};
  localparam int VSW [0:1] = '{4, 2};
  localparam int HBE [0:1] = '{60, 6};
  localparam int HBS [0:1] = '{341, 38};
  localparam int VBL [0:1] = '{8, 3};
  localparam int DV  [0:1] = '{2, 3};

  logic clk = 1'b0;
  logic RESET, ena, is_pal, raw_sel, vdp_hs_n, vdp_vs_n;
  logic [5:0] vdp_r, vdp_g, vdp_b;

  logic hs0, vs0, hb0, vb0, pal0, frame0;
  logic [5:0] r0, g0, b0;
  logic [9:0] hcnt0, vcnt0;
  logic hs1, vs1, hb1, vb1, pal1, frame1;
  logic [5:0] r1, g1, b1;
  logic [7:0] hcnt1, vcnt1;

  int n_checks = 0;
  int n_errors = 0;

  // model state: linear position inside the frame, ena count inside the prescale period
  int pos [0:1];
  int ecnt [0:1];
  bit mpal [0:1], s1 [0:1], s2 [0:1];
  bit e_hs [0:1], e_vs [0:1], e_hb [0:1], e_vb [0:1], e_fr [0:1];
  int e_r [0:1], e_g [0:1], e_b [0:1];
  bit mv = 1'b0;

  always #5 clk = ~clk;

  vdp_video_timing dut0 (
    .clk(clk), .RESET(RESET), .ena(ena), .is_pal(is_pal), .raw_sel(raw_sel),
    .vdp_hs_n(vdp_hs_n), .vdp_vs_n(vdp_vs_n), .vdp_r(vdp_r), .vdp_g(vdp_g), .vdp_b(vdp_b),
    .HS(hs0), .VS(vs0), .R(r0), .G(g0), .B(b0), .HBlank(hb0), .VBlank(vb0),
    .hcnt(hcnt0), .vcnt(vcnt0), .pal(pal0), .frame(frame0)
  );

  vdp_video_timing #(
    .COLOR_W(6), .CNT_W(8), .DIV(3), .H_TOTAL(40), .V_TOTAL_NTSC(21), .V_TOTAL_PAL(26),
    .H_START(34), .HS_WIDTH(4), .VS_WIDTH(2), .HBLANK_END(6), .HBLANK_START(38), .VBLANK_LINES(3)
  ) dut1 (
    .clk(clk), .RESET(RESET), .ena(ena), .is_pal(is_pal), .raw_sel(raw_sel),
    .vdp_hs_n(vdp_hs_n), .vdp_vs_n(vdp_vs_n), .vdp_r(vdp_r), .vdp_g(vdp_g), .vdp_b(vdp_b),
    .HS(hs1), .VS(vs1), .R(r1), .G(g1), .B(b1), .HBlank(hb1), .VBlank(vb1),
    .hcnt(hcnt1), .vcnt(vcnt1), .pal(pal1), .frame(frame1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_checks++;
    n_errors++;
    $display("FAIL %s: wait expired at %0t", nm, $time);
  endtask

  task automatic model_update(input int i);
    int h, v, vtot;
    bit hb, vb, raw;
    if (RESET) begin
      pos[i] = HST[i]; ecnt[i] = 0; mpal[i] = 1'b0; s1[i] = 1'b0; s2[i] = 1'b0;
      e_hs[i] = 1'b1; e_vs[i] = 1'b1; e_hb[i] = 1'b1; e_vb[i] = 1'b1; e_fr[i] = 1'b0;
      e_r[i] = 0; e_g[i] = 0; e_b[i] = 0;
    end else begin
      h = pos[i] % HT[i];
      v = pos[i] / HT[i];
      hb = (h < HBE[i]) || (h >= HBS[i]);
      vb = (v < VBL[i]);
`ifdef VDP_TIMING_RAW_EN
      raw = raw_sel;
`else
      raw = 1'b0;
`endif
      if (raw) begin
        e_hs[i] = vdp_hs_n; e_vs[i] = vdp_vs_n;
        e_r[i] = vdp_r; e_g[i] = vdp_g; e_b[i] = vdp_b;
      end else begin
        e_hs[i] = (h >= HSW[i]); e_vs[i] = (v >= VSW[i]);
        e_r[i] = (hb || vb) ? 0 : int'(vdp_r);
        e_g[i] = (hb || vb) ? 0 : int'(vdp_g);
        e_b[i] = (hb || vb) ? 0 : int'(vdp_b);
      end
      e_hb[i] = hb;
      e_vb[i] = vb;
      e_fr[i] = 1'b0;
      if (ena) begin
        ecnt[i]++;
        if (ecnt[i] == DV[i]) begin
          ecnt[i] = 0;
          pos[i]++;
          vtot = mpal[i] ? VP[i] : VN[i];
          if (pos[i] == vtot * HT[i]) begin
            pos[i] = 0;
            e_fr[i] = 1'b1;
            mpal[i] = s2[i];
          end
        end
      end
      s2[i] = s1[i];
      s1[i] = is_pal;
    end
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_update(i);
    if (RESET) mv = 1'b1;
    @(negedge clk);
  endtask

  task automatic cmp(input int i, input logic [31:0] hc, input logic [31:0] vc,
                     input logic hs, input logic vs, input logic hb, input logic vb,
                     input logic pl, input logic fr,
                     input logic [31:0] r, input logic [31:0] g, input logic [31:0] b);
    string sx;
    sx = (i == 0) ? "0" : "1";
    chk({"hcnt", sx}, hc, pos[i] % HT[i]);
    chk({"vcnt", sx}, vc, pos[i] / HT[i]);
    chk({"HS", sx}, {31'd0, hs}, {31'd0, e_hs[i]});
    chk({"VS", sx}, {31'd0, vs}, {31'd0, e_vs[i]});
    chk({"HBlank", sx}, {31'd0, hb}, {31'd0, e_hb[i]});
    chk({"VBlank", sx}, {31'd0, vb}, {31'd0, e_vb[i]});
    chk({"pal", sx}, {31'd0, pl}, {31'd0, mpal[i]});
    chk({"frame", sx}, {31'd0, fr}, {31'd0, e_fr[i]});
    chk({"R", sx}, r, e_r[i]);
    chk({"G", sx}, g, e_g[i]);
    chk({"B", sx}, b, e_b[i]);
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (mv) begin
      cmp(0, {22'd0, hcnt0}, {22'd0, vcnt0}, hs0, vs0, hb0, vb0, pal0, frame0,
          {26'd0, r0}, {26'd0, g0}, {26'd0, b0});
      cmp(1, {24'd0, hcnt1}, {24'd0, vcnt1}, hs1, vs1, hb1, vb1, pal1, frame1,
          {26'd0, r1}, {26'd0, g1}, {26'd0, b1});
    end
  end

  task automatic wait_hv0(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(hcnt0) == h && int'(vcnt0) == v) && n < 8000) begin
      step();
      n++;
    end
    if (n >= 8000) fail_timeout("wait_hv0");
  endtask

  task automatic wait_hv1(input int h, input int v);
    int n;
    n = 0;
    while (!(int'(hcnt1) == h && int'(vcnt1) == v) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) fail_timeout("wait_hv1");
  endtask

  task automatic wait_frame1(output int pv);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    pv = -1;
    while (!seen && n < 4000) begin
      pv = int'(vcnt1);
      step();
      n++;
      seen = frame1;
    end
    if (!seen) fail_timeout("wait_frame1");
  endtask

  initial begin
    int pv;
    RESET = 1'b1; ena = 1'b0; is_pal = 1'b0; raw_sel = 1'b0;
    vdp_hs_n = 1'b1; vdp_vs_n = 1'b1;
    vdp_r = 6'h3F; vdp_g = 6'h3F; vdp_b = 6'h3F;
    repeat (3) step();
    chk("rst_hcnt0", {22'd0, hcnt0}, 32'd306);
    chk("rst_vcnt0", {22'd0, vcnt0}, 32'd0);
    chk("rst_hs0", {31'd0, hs0}, 32'd1);
    chk("rst_hb0", {31'd0, hb0}, 32'd1);
    chk("rst_r0", {26'd0, r0}, 32'd0);
    chk("rst_hcnt1", {24'd0, hcnt1}, 32'd34);

    // line 0 of the default geometry, ena every clk
    RESET = 1'b0; ena = 1'b1;
    step(); chk("l0_hcnt_a", {22'd0, hcnt0}, 32'd306);
    step(); chk("l0_hcnt_b", {22'd0, hcnt0}, 32'd307);
    repeat (70) step();
    chk("wrap_hcnt0", {22'd0, hcnt0}, 32'd0);
    chk("wrap_vcnt0", {22'd0, vcnt0}, 32'd1);
    wait_hv0(19, 1); step(); chk("hs_low_19", {31'd0, hs0}, 32'd0);
    chk("vs_low_l1", {31'd0, vs0}, 32'd0);
    wait_hv0(20, 1); step(); chk("hs_high_20", {31'd0, hs0}, 32'd1);
    wait_hv0(100, 1); step(); chk("rgb_vblank", {26'd0, r0}, 32'd0);
    wait_hv0(59, 8); step(); chk("rgb_h59", {26'd0, r0}, 32'd0);
    wait_hv0(60, 8); step(); chk("rgb_h60", {26'd0, r0}, 32'd63);
    chk("vb_off_l8", {31'd0, vb0}, 32'd0);
    wait_hv0(340, 8); step(); chk("rgb_h340", {26'd0, g0}, 32'd63);
    wait_hv0(341, 8); step(); chk("rgb_h341", {26'd0, b0}, 32'd0);

    // raw bypass request
    raw_sel = 1'b1; vdp_hs_n = 1'b0; vdp_r = 6'h15;
    wait_hv0(150, 9); step();
`ifdef VDP_TIMING_RAW_EN
    chk("raw_hs", {31'd0, hs0}, 32'd0);
`else
    chk("raw_hs", {31'd0, hs0}, 32'd1);
`endif
    wait_hv0(10, 10); step();
`ifdef VDP_TIMING_RAW_EN
    chk("raw_rgb_blank", {26'd0, r0}, 32'd21);
`else
    chk("raw_rgb_blank", {26'd0, r0}, 32'd0);
`endif
    raw_sel = 1'b0; vdp_hs_n = 1'b1;

    // randomized traffic
    for (int k = 0; k < 3000; k++) begin
      ena = ($urandom_range(0, 3) != 0);
      vdp_r = 6'($urandom); vdp_g = 6'($urandom); vdp_b = 6'($urandom);
      raw_sel = 1'($urandom_range(0, 1));
      vdp_hs_n = 1'($urandom_range(0, 1));
      vdp_vs_n = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0) is_pal = ~is_pal;
      step();
    end

    // standard switching on the reduced geometry
    RESET = 1'b1; ena = 1'b1; is_pal = 1'b0; raw_sel = 1'b0;
    step();
    RESET = 1'b0;
    wait_hv1(0, 10);
    is_pal = 1'b1;
    wait_frame1(pv);
    chk("ntsc_last_line", pv, 32'd20);
    chk("pal_after_wrap", {31'd0, pal1}, 32'd1);
    step(); chk("frame_one_clk", {31'd0, frame1}, 32'd0);
    wait_hv1(0, 23);
    is_pal = 1'b0;
    chk("pal_held", {31'd0, pal1}, 32'd1);
    wait_frame1(pv);
    chk("pal_last_line", pv, 32'd25);
    chk("ntsc_back", {31'd0, pal1}, 32'd0);
    wait_frame1(pv);
    chk("ntsc_again", pv, 32'd20);

    // reset in mid-frame
    wait_hv1(20, 15);
    RESET = 1'b1;
    step();
    chk("mid_hcnt1", {24'd0, hcnt1}, 32'd34);
    chk("mid_vcnt1", {24'd0, vcnt1}, 32'd0);
    chk("mid_frame1", {31'd0, frame1}, 32'd0);
    chk("mid_vs1", {31'd0, vs1}, 32'd1);
    chk("mid_vb1", {31'd0, vb1}, 32'd1);
    chk("mid_hcnt0", {22'd0, hcnt0}, 32'd306);
    RESET = 1'b0;
    for (int k = 0; k < 500; k++) begin
      ena = ($urandom_range(0, 1) != 0);
      vdp_r = 6'($urandom); vdp_g = 6'($urandom); vdp_b = 6'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
